// File: rtl/fp_normalize_round.sv
// Post-add normalize / round-to-nearest-even / pack stage of the binary32 adder.
// Two registered stages sharing one enable, so a stalled output freezes the whole pipe.
module fp_normalize_round #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic [EXP_W-1:0]        in_exp,
  input  logic [FRAC_W+4:0]       in_mant,
  input  logic                    in_special,
  input  logic [EXP_W+FRAC_W:0]   in_special_val,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   out_result,
  output logic                    out_ovf,
  output logic                    out_unf,
  output logic                    out_inexact
);

  localparam int MW = FRAC_W + 5;
  localparam int NW = FRAC_W + 4;
  localparam int EW = EXP_W + 2;
  localparam int LW = $clog2(NW + 1);
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

  logic en;

  // stage 1 combinational
  logic [LW-1:0]        lzc;
  logic                 found;
  logic [NW-1:0]        n_mant;
  logic signed [EW-1:0] n_e;

  // stage 1 registers
  logic                    s1_valid;
  logic                    s1_sign;
  logic                    s1_zero;
  logic                    s1_special;
  logic [EXP_W+FRAC_W:0]   s1_special_val;
  logic signed [EW-1:0]    s1_e;
  logic [FRAC_W+2:0]       s1_mant;   // fraction, G, R, S (hidden bit implied)

  // stage 2 combinational
  logic                    rnd_up;
  logic                    carry;
  logic [FRAC_W-1:0]       frac_r;
  logic [FRAC_W-1:0]       frac;
  logic signed [EW-1:0]    e2;
  logic [EXP_W+FRAC_W:0]   r_result;
  logic                    r_ovf;
  logic                    r_unf;
  logic                    r_inexact;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  always_comb begin
    lzc   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NW; i++) begin
      if (!found && in_mant[NW-1-i]) begin
        lzc   = LW'(i);
        found = 1'b1;
      end
    end
    if (in_mant[MW-1]) begin
      n_mant = {in_mant[MW-1:2], in_mant[1] | in_mant[0]};
      n_e    = $signed({2'b00, in_exp}) + EW'(1);
    end else begin
      n_mant = in_mant[NW-1:0] << lzc;
      n_e    = $signed({2'b00, in_exp}) - $signed(EW'(lzc));
    end
  end

  // Hidden bit is always 1 for a nonzero normalized mantissa, so rounding only
  // adds into the fraction; a carry out of the fraction means the value hit 2.0.
  always_comb begin
    rnd_up          = s1_mant[2] & (s1_mant[1] | s1_mant[0] | s1_mant[3]);
    {carry, frac_r} = {1'b0, s1_mant[FRAC_W+2:3]} + (FRAC_W+1)'(rnd_up);
    frac            = carry ? '0 : frac_r;
    e2              = s1_e + $signed({{(EW-1){1'b0}}, carry});
    r_result        = '0;
    r_ovf           = 1'b0;
    r_unf           = 1'b0;
    r_inexact       = 1'b0;
    if (s1_special) begin
      r_result = s1_special_val;
    end else if (s1_zero) begin
      r_result = {s1_sign, {(EXP_W+FRAC_W){1'b0}}};
    end else if (!e2[EW-1] && e2 >= EMAX) begin
      r_result  = {s1_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      r_ovf     = 1'b1;
      r_inexact = 1'b1;
    end else if (e2[EW-1] || e2 == '0) begin
      r_result  = {s1_sign, {(EXP_W+FRAC_W){1'b0}}};
      r_unf     = 1'b1;
      r_inexact = 1'b1;
    end else begin
      r_result  = {s1_sign, e2[EXP_W-1:0], frac};
      r_inexact = |s1_mant[2:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid       <= 1'b0;
      s1_sign        <= 1'b0;
      s1_zero        <= 1'b0;
      s1_special     <= 1'b0;
      s1_special_val <= '0;
      s1_e           <= '0;
      s1_mant        <= '0;
      out_valid      <= 1'b0;
      out_result     <= '0;
      out_ovf        <= 1'b0;
      out_unf        <= 1'b0;
      out_inexact    <= 1'b0;
    end else if (en) begin
      s1_valid       <= in_valid;
      s1_sign        <= in_sign;
      s1_zero        <= !n_mant[NW-1];
      s1_special     <= in_special;
      s1_special_val <= in_special_val;
      s1_e           <= n_e;
      s1_mant        <= n_mant[NW-2:0];
      out_valid      <= s1_valid;
      out_result     <= r_result;
      out_ovf        <= r_ovf;
      out_unf        <= r_unf;
      out_inexact    <= r_inexact;
    end
  end

endmodule
